// File: rtl/minority_checker_pkg.sv
// Shared types and the golden minority function for the minority-of-N response checker.
package minority_checker_pkg;

    localparam int N_IN_DEF = 3;

    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_e;

    // Caller passes its vector zero-extended to 15 bits plus its real width n.
    function automatic logic minority_ref(input logic [14:0] vec, input int n);
        int ones;
        ones = 0;
        for (int i = 0; i < 15; i++) begin
            if (i < n) ones += int'(vec[i]);
        end
        return (ones * 2 < n);
    endfunction

endpackage

// File: rtl/minority_checker_if.sv
// Handshake bus carrying (input vector, observed output) pairs into the checker.
interface minority_checker_if #(parameter int N_IN = 3);
    logic            in_valid;
    logic            in_ready;
    logic [N_IN-1:0] in_vec;
    logic            in_y;

    modport master (output in_valid, in_vec, in_y, input in_ready);
    modport slave  (input in_valid, in_vec, in_y, output in_ready);
endinterface

// File: rtl/minority_checker.sv
// Receives exhaustive (vector, y) pairs, checks y against the minority function and
// reports mismatch count, ordering errors and the first failing vector.
module minority_checker
    import minority_checker_pkg::*;
#(
    parameter int N_IN    = N_IN_DEF,
    parameter int NUM_VEC = 2 ** N_IN,
    parameter int CNT_W   = N_IN + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    minority_checker_if.slave bus,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic              seq_err,
    output logic [CNT_W-1:0]  vec_count,
    output logic [N_IN-1:0]   first_fail_vec,
    output logic              first_fail_valid
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic             seq_q, seq_d;
    logic [N_IN-1:0]  ffvec_q, ffvec_d;
    logic             ffv_q, ffv_d;

    logic accept, last, run_clr, exp_y;

    assign accept = bus.in_valid && (state_q == CHECK);
    assign last   = (vcnt_q == CNT_W'(NUM_VEC - 1));
    assign exp_y  = minority_ref(15'(bus.in_vec), N_IN);

    always_comb begin
        state_d = state_q;
        run_clr = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = CHECK;
                    run_clr = 1'b1;
                end
            end
            CHECK: begin
                if (accept && last) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The golden compare uses the received vector even when it is out of order.
    always_comb begin
        err_d   = err_q;
        vcnt_d  = vcnt_q;
        seq_d   = seq_q;
        ffvec_d = ffvec_q;
        ffv_d   = ffv_q;
        if (run_clr) begin
            err_d   = '0;
            vcnt_d  = '0;
            seq_d   = 1'b0;
            ffvec_d = '0;
            ffv_d   = 1'b0;
        end else if (accept) begin
            vcnt_d = vcnt_q + CNT_W'(1);
            if (bus.in_vec != vcnt_q[N_IN-1:0]) seq_d = 1'b1;
            if (bus.in_y != exp_y) begin
                if (err_q != {CNT_W{1'b1}}) err_d = err_q + CNT_W'(1);
                if (!ffv_q) begin
                    ffvec_d = bus.in_vec;
                    ffv_d   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            err_q   <= '0;
            vcnt_q  <= '0;
            seq_q   <= 1'b0;
            ffvec_q <= '0;
            ffv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            vcnt_q  <= vcnt_d;
            seq_q   <= seq_d;
            ffvec_q <= ffvec_d;
            ffv_q   <= ffv_d;
        end
    end

    assign bus.in_ready     = (state_q == CHECK);
    assign busy             = (state_q == CHECK);
    assign done             = (state_q == DONE);
    assign pass             = done && (err_q == '0) && !seq_q;
    assign err_count        = err_q;
    assign seq_err          = seq_q;
    assign vec_count        = vcnt_q;
    assign first_fail_vec   = ffvec_q;
    assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_minority_checker.sv
// Scoreboard bench: each run pushes its hand-computed result, a monitor checks it when done rises.
module tb_minority_checker;
    import minority_checker_pkg::*;

    localparam int N  = 3;
    localparam int CW = N + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, pass, seq_err, first_fail_valid;
    logic [CW-1:0] err_count, vec_count;
    logic [N-1:0]  first_fail_vec;

    minority_checker_if #(.N_IN(N)) bus ();

    minority_checker #(.N_IN(N)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .seq_err(seq_err), .vec_count(vec_count),
        .first_fail_vec(first_fail_vec), .first_fail_valid(first_fail_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int pass_e;
        int err_e;
        int seq_e;
        int vc_e;
        int ffv_e;
        int ffvec_e;
        int done_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops the oldest expectation on each rising edge of done.
    logic done_d = 1'b0;
    always @(negedge clk) begin
        if (reset && done && !done_d) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                chk("done_cycle", cyc, sb[0].done_cyc);
                chk("pass", int'(pass), sb[0].pass_e);
                chk("err_count", int'(err_count), sb[0].err_e);
                chk("seq_err", int'(seq_err), sb[0].seq_e);
                chk("vec_count", int'(vec_count), sb[0].vc_e);
                chk("first_fail_valid", int'(first_fail_valid), sb[0].ffv_e);
                if (sb[0].ffv_e != 0) chk("first_fail_vec", int'(first_fail_vec), sb[0].ffvec_e);
                void'(sb.pop_front());
            end
        end
        done_d <= done;
    end

    task automatic idle_bus();
        bus.in_valid = 1'b0;
        bus.in_vec   = '0;
        bus.in_y     = 1'b0;
    endtask

    // vecs[i]/ys[i]: i-th pair sent. Expected results are hand-computed by the caller.
    task automatic run_seq(input logic [7:0][N-1:0] vecs, input logic [7:0] ys, input bit gappy,
                           input int e_pass, input int e_err, input int e_seq,
                           input int e_ffv, input int e_ffvec);
        int   gaps[8];
        int   tot;
        exp_t e;
        tot = 0;
        for (int i = 0; i < 8; i++) begin
            gaps[i] = gappy ? int'($urandom_range(0, 3)) : 0;
            tot += gaps[i];
        end
        @(negedge clk);
        start = 1'b1;
        // Start cycle is cycle 0; back-to-back data puts done at cycle 9.
        e = '{e_pass, e_err, e_seq, 8, e_ffv, e_ffvec, cyc + 9 + tot};
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        chk("clr_err_count", int'(err_count), 0);
        chk("clr_vec_count", int'(vec_count), 0);
        chk("clr_done", int'(done), 0);
        chk("clr_ffv", int'(first_fail_valid), 0);
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                idle_bus();
                chk("ready_in_gap", int'(bus.in_ready), 1);
                @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_vec   = vecs[i];
            bus.in_y     = ys[i];
            @(negedge clk);
        end
        idle_bus();
        for (int k = 0; k < 30 && !done; k++) @(negedge clk);
        if (!done) chk("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    logic [7:0][N-1:0] asc, swp;

    initial begin
        idle_bus();
        for (int i = 0; i < 8; i++) asc[i] = 3'(i);
        swp = asc;
        swp[2] = 3'd3;
        swp[3] = 3'd2;

        repeat (2) @(negedge clk);
        chk("rst_ready", int'(bus.in_ready), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err_count), 0);
        reset = 1'b1;
        @(negedge clk);

        // 1: clean run
        run_seq(asc, 8'b0001_0111, 1'b0, 1, 0, 0, 0, 0);
        // 2: vector 5 wrong
        run_seq(asc, 8'b0011_0111, 1'b0, 0, 1, 0, 1, 5);
        // 3: every output inverted
        run_seq(asc, 8'b1110_1000, 1'b0, 0, 8, 0, 1, 0);
        // 6: restart from DONE after a failing run
        run_seq(asc, 8'b0001_0111, 1'b0, 1, 0, 0, 0, 0);
        // 4: 3 and 2 swapped, correct y for what was sent, random bubbles
        run_seq(swp, 8'b0001_1011, 1'b1, 0, 0, 1, 0, 0);

        // 5: reset after 4 acceptances
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_vec   = 3'(i);
            bus.in_y     = (i == 3) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        chk("mid_vec_count", int'(vec_count), 4);
        idle_bus();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mrst_ready", int'(bus.in_ready), 0);
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_pass", int'(pass), 0);
        chk("mrst_err", int'(err_count), 0);
        chk("mrst_seq", int'(seq_err), 0);
        chk("mrst_vc", int'(vec_count), 0);
        chk("mrst_ffv", int'(first_fail_valid), 0);
        chk("mrst_ffvec", int'(first_fail_vec), 0);
        @(negedge clk);
        chk("mrst_stays_idle", int'(busy), 0);
        run_seq(asc, 8'b0001_0111, 1'b1, 1, 0, 0, 0, 0);

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        if (sb.size() != 0) chk("scoreboard_drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/minority_checker.md
Name: minority_checker

Overview:
- Hardware response checker: the receiving end of an exhaustive stimulus stream for a minority-of-N gate.
- Accepts (input vector, DUT output) pairs over a valid/ready handshake and compares each output against a golden minority function.
- Counts mismatches, checks that vectors arrive in ascending order, records the first failing vector and reports pass/fail once all 2^N_IN vectors are consumed.
- Sits beside a stimulus generator and a DUT in on-chip self-test.

Parameters:
- N_IN, 3, DUT input width; must be odd, 1..15.
- NUM_VEC, 2**N_IN, number of vectors per run.
- CNT_W, N_IN+1, width of the error and vector counters.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-low reset; reset==0 at a rising edge resets the block
- start  input  1  begins a run; sampled only in IDLE or DONE
- in_valid  input  1  producer has a pair on in_vec/in_y
- in_ready  output  1  checker accepts a pair this cycle
- in_vec  input  N_IN  DUT input vector applied
- in_y  input  1  DUT output observed for in_vec
- busy  output  1  run in progress
- done  output  1  run complete; held until the next start
- pass  output  1  valid when done; 1 = no mismatches and no sequence error
- err_count  output  CNT_W  number of output mismatches
- seq_err  output  1  sticky; some in_vec differed from the expected index
- vec_count  output  CNT_W  pairs accepted this run
- first_fail_vec  output  N_IN  in_vec of the first mismatch
- first_fail_valid  output  1  first_fail_vec holds a capture

Behaviour:

Reset (reset==0 at a rising edge):
- State goes to IDLE.
- All outputs go to 0: in_ready, busy, done, pass, err_count, seq_err, vec_count, first_fail_vec, first_fail_valid.
- Reset mid-run abandons the run; no partial results are retained.

Golden function:
- exp = 1 iff popcount(in_vec)*2 < N_IN (at most floor(N_IN/2) ones).
- For N_IN=3: exp=1 for vectors 0,1,2,4; exp=0 for 3,5,6,7.

FSM states: IDLE, CHECK, DONE.
- IDLE: in_ready=0, busy=0. start=1 -> CHECK.
- CHECK: in_ready=1, busy=1.
  - Acceptance occurs when in_valid && in_ready.
  - On the acceptance making vec_count reach NUM_VEC -> DONE.
  - start is ignored in CHECK.
- DONE: in_ready=0, busy=0, done=1, pass = (err_count==0) && !seq_err.
  - start=1 -> CHECK (new run).

Entering CHECK from IDLE or DONE:
- Clears err_count, vec_count, seq_err, first_fail_valid, first_fail_vec, done and pass in the same edge.

On each acceptance (all updates visible the cycle after the accept edge):
- vec_count increments by 1.
- If in_vec != vec_count[N_IN-1:0] (value before increment), seq_err sets. It is sticky for the run.
- The comparison still uses the exp of the received in_vec, not of the expected index.
- If in_y != exp:
  - err_count increments, saturating at 2^CNT_W-1.
  - If first_fail_valid==0: capture first_fail_vec=in_vec and set first_fail_valid.

Timing:
- Latency: done and pass rise on the cycle after the final acceptance.
- Minimum run length is NUM_VEC+1 cycles from start to done, with in_valid held high.
- Bubbles (in_valid=0) stall the run without limit; there is no timeout.
- Inputs are ignored when in_ready=0; the producer holds in_vec/in_y stable while in_valid=1 and not accepted.

Simultaneous events:
- A start in the same cycle as the last acceptance is ignored, because the state is CHECK.
- reset==0 overrides everything.

Decomposition:
- Package minority_checker_pkg holds:
  - the state typedef (enum logic [1:0] {IDLE, CHECK, DONE});
  - the function minority_ref(vec), parameterized by width through the caller;
  - a localparam for the default N_IN.
- No sub-module: a single module with the FSM and datapath counters.

Test Plan:
1. Clean run, N_IN=3: start, then vectors 0..7 back-to-back with y=1,1,1,0,1,0,0,0 -> done=1 at cycle 9 after start, pass=1, err_count=0, vec_count=8, first_fail_valid=0.
2. Single fault: as test 1 but vector 5 sends y=1 -> err_count=1, first_fail_vec=5, first_fail_valid=1, pass=0.
3. Multiple faults: all eight y values inverted -> err_count=8, first_fail_vec=0, pass=0.
4. Ordering and stalls:
   - Vectors 0,1,3,2,4,5,6,7 with correct y and random in_valid gaps -> seq_err=1, err_count=0, pass=0.
   - in_ready stays 1 throughout the gaps.
5. Reset mid-run: pull reset low after 4 acceptances -> next cycle all outputs are 0 and state is IDLE; a fresh run then passes.
6. Restart from DONE: after a failing run, pulse start -> counters clear the next cycle; a clean sequence gives pass=1.
